wbn_master: RTL and testbench
=============================

Name: wbn_master

Overview:
Wishbone 3 classic (non-pipelined) initiator. It accepts single-beat read/write commands on a valid/ready request channel and runs exactly one Wishbone cycle per command. Terminations are ack, err, rty (with bounded automatic retry) or a local timeout. It returns data and status on a valid/ready response channel, and it drives the master side of the Wishbone slave-port signal set used by our peripherals.

Parameters:
AW, 32, address width
DW, 32, data width
SW, DW/8, byte select width
RETRY_MAX, 3, automatic reissues after rty; 0 means no retry
TIMEOUT, 255, max cycles waiting for a termination per attempt; 0 disables timeout

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
req_vld  input  1  command valid
req_rdy  output  1  command ready
req_we  input  1  1=write, 0=read
req_adr  input  AW  command address
req_sel  input  SW  command byte select
req_dat  input  DW  write data
rsp_vld  output  1  response valid
rsp_rdy  input  1  response ready
rsp_dat  output  DW  read data; 0 for writes and non-ok status
rsp_sts  output  2  00=ok, 01=err, 10=retry exhausted, 11=timeout
cyc  output  1  Wishbone cycle
stb  output  1  Wishbone strobe
we  output  1  Wishbone write enable
adr  output  AW  Wishbone address
sel  output  SW  Wishbone byte select
dat_w  output  DW  Wishbone write data
dat_r  input  DW  Wishbone read data
ack  input  1  Wishbone acknowledge
err  input  1  Wishbone error
rty  input  1  Wishbone retry

Behaviour:
- Single clock clk; reset is asynchronous and active-high on rst. All state and outputs are registered.
- Reset values: state=IDLE; cyc, stb, we, rsp_vld = 0; adr, sel, dat_w, rsp_dat, rsp_sts = 0; retry and timeout counters = 0. req_rdy=1 after reset.
- FSM states: IDLE, BUS, GAP, RSP.
- IDLE:
  - req_rdy=1.
  - On req_vld&&req_rdy: latch we/adr/sel/dat into the bus registers, clear both counters, go to BUS.
  - cyc=stb=1 from the next cycle.
- BUS:
  - cyc=stb=1; adr/sel/we/dat_w held stable.
  - Sample terminations every cycle, priority err > ack > rty.
  - err: cyc=stb=0 next cycle, sts=01 -> RSP.
  - ack: capture dat_r if read (0 if write), sts=00 -> RSP.
  - rty with retry_cnt<RETRY_MAX: retry_cnt++, clear timeout counter, cyc=stb=0 -> GAP.
  - rty with retry_cnt==RETRY_MAX: sts=10 -> RSP.
  - No termination: tmo_cnt++. If TIMEOUT!=0 and tmo_cnt reaches TIMEOUT-1 in this cycle, sts=11 -> RSP. Exactly TIMEOUT cycles with stb high and no termination abort the attempt.
- GAP: exactly one idle cycle with cyc=stb=0, then return to BUS with the same latched command.
- RSP:
  - rsp_vld=1; rsp_dat/rsp_sts held stable until rsp_rdy.
  - cyc=stb=0.
  - On rsp_rdy go to IDLE; req_rdy=1 the following cycle. No request/response overlap (one outstanding command).
- Latency: earliest ack is in the first BUS cycle, giving req handshake -> rsp_vld in 2 cycles (req accept at edge N, cyc at N+1, ack sampled at N+1 edge, rsp_vld at N+2).
- Terminations arriving in IDLE, GAP or RSP are ignored.
- Reset mid-cycle drops cyc/stb immediately (asynchronous), discards the command and does not produce a response.
- Counter widths: $clog2(RETRY_MAX+1) and $clog2(TIMEOUT+1), minimum 1 bit.

Test Plan:
- Read adr=0x10, sel=0xF; slave acks 3 cycles after stb with dat_r=0xDEADBEEF -> cyc/stb high exactly 3 cycles then dropped; rsp_dat=0xDEADBEEF, rsp_sts=00; adr stable throughout.
- Write adr=0x20, dat=0x12345678, sel=0x3; immediate ack -> we=1, dat_w=0x12345678, sel=0x3 on bus; rsp_vld 2 cycles after accept; rsp_dat=0, sts=00.
- RETRY_MAX=2; slave returns rty, rty, then ack -> three stb attempts, each separated by one cyc=0 gap cycle; sts=00. Repeat with rty ×3 -> sts=10 after the third attempt.
- err and ack asserted together -> sts=01, rsp_dat=0. With TIMEOUT=8 and no termination -> stb high exactly 8 cycles; sts=11.
- Hold rsp_rdy=0 for 5 cycles -> rsp_vld, rsp_dat and rsp_sts stable, req_rdy=0. Assert rst in BUS -> cyc=stb=0 without a clock edge, no rsp_vld; the next command completes normally.

Source files
------------

// File: rtl/wbn_master.sv
// Wishbone B3 classic initiator: one bus cycle per valid/ready command.
// A retry (rty) reissues the command after one idle gap cycle; timeout is counted per attempt.
module wbn_master #(
    parameter int unsigned AW        = 32,
    parameter int unsigned DW        = 32,
    parameter int unsigned SW        = DW / 8,
    parameter int unsigned RETRY_MAX = 3,
    parameter int unsigned TIMEOUT   = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_vld,
    output logic          req_rdy,
    input  logic          req_we,
    input  logic [AW-1:0] req_adr,
    input  logic [SW-1:0] req_sel,
    input  logic [DW-1:0] req_dat,
    output logic          rsp_vld,
    input  logic          rsp_rdy,
    output logic [DW-1:0] rsp_dat,
    output logic [1:0]    rsp_sts,
    output logic          cyc,
    output logic          stb,
    output logic          we,
    output logic [AW-1:0] adr,
    output logic [SW-1:0] sel,
    output logic [DW-1:0] dat_w,
    input  logic [DW-1:0] dat_r,
    input  logic          ack,
    input  logic          err,
    input  logic          rty
);

    localparam int unsigned RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);
    localparam logic [TW-1:0] TMO_LAST   = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUS  = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    localparam logic [1:0] STS_OK  = 2'b00;
    localparam logic [1:0] STS_ERR = 2'b01;
    localparam logic [1:0] STS_RTY = 2'b10;
    localparam logic [1:0] STS_TMO = 2'b11;

    logic [1:0]    state_q,   state_d;
    logic          req_rdy_q, req_rdy_d;
    logic          cyc_q,     cyc_d;
    logic          stb_q,     stb_d;
    logic          we_q,      we_d;
    logic [AW-1:0] adr_q,     adr_d;
    logic [SW-1:0] sel_q,     sel_d;
    logic [DW-1:0] dat_w_q,   dat_w_d;
    logic          rsp_vld_q, rsp_vld_d;
    logic [DW-1:0] rsp_dat_q, rsp_dat_d;
    logic [1:0]    rsp_sts_q, rsp_sts_d;
    logic [RW-1:0] retry_q,   retry_d;
    logic [TW-1:0] tmo_q,     tmo_d;

    // State and registered outputs; reset drops cyc/stb without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_rdy_q <= 1'b1;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            adr_q     <= '0;
            sel_q     <= '0;
            dat_w_q   <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
            rsp_sts_q <= STS_OK;
            retry_q   <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_rdy_q <= req_rdy_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            adr_q     <= adr_d;
            sel_q     <= sel_d;
            dat_w_q   <= dat_w_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_sts_q <= rsp_sts_d;
            retry_q   <= retry_d;
            tmo_q     <= tmo_d;
        end
    end

    // Next state; terminations are only honoured in BUS, with priority err > ack > rty.
    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        adr_d     = adr_q;
        sel_d     = sel_q;
        dat_w_d   = dat_w_q;
        rsp_dat_d = rsp_dat_q;
        rsp_sts_d = rsp_sts_q;
        retry_d   = retry_q;
        tmo_d     = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (req_vld && req_rdy_q) begin
                    we_d    = req_we;
                    adr_d   = req_adr;
                    sel_d   = req_sel;
                    dat_w_d = req_dat;
                    retry_d = '0;
                    tmo_d   = '0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                if (err) begin
                    rsp_sts_d = STS_ERR;
                    rsp_dat_d = '0;
                    state_d   = S_RSP;
                end else if (ack) begin
                    rsp_sts_d = STS_OK;
                    rsp_dat_d = we_q ? '0 : dat_r;
                    state_d   = S_RSP;
                end else if (rty) begin
                    if (retry_q < RETRY_LAST) begin
                        retry_d = retry_q + RW'(1);
                        tmo_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        rsp_sts_d = STS_RTY;
                        rsp_dat_d = '0;
                        state_d   = S_RSP;
                    end
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    if ((TIMEOUT != 0) && (tmo_q == TMO_LAST)) begin
                        rsp_sts_d = STS_TMO;
                        rsp_dat_d = '0;
                        state_d   = S_RSP;
                    end
                end
            end
            S_GAP: begin
                state_d = S_BUS;
            end
            S_RSP: begin
                if (rsp_rdy) begin
                    state_d = S_IDLE;
                end
            end
        endcase

        cyc_d     = (state_d == S_BUS);
        stb_d     = (state_d == S_BUS);
        rsp_vld_d = (state_d == S_RSP);
        req_rdy_d = (state_d == S_IDLE);
    end

    assign req_rdy = req_rdy_q;
    assign cyc     = cyc_q;
    assign stb     = stb_q;
    assign we      = we_q;
    assign adr     = adr_q;
    assign sel     = sel_q;
    assign dat_w   = dat_w_q;
    assign rsp_vld = rsp_vld_q;
    assign rsp_dat = rsp_dat_q;
    assign rsp_sts = rsp_sts_q;

endmodule

// File: tb/tb_wbn_master.sv
// Directed bench for wbn_master (RETRY_MAX=2, TIMEOUT=8): bus protocol, retry, timeout, reset.
module tb_wbn_master;

    logic        clk;
    logic        rst;
    logic        req_vld;
    logic        req_rdy;
    logic        req_we;
    logic [31:0] req_adr;
    logic [3:0]  req_sel;
    logic [31:0] req_dat;
    logic        rsp_vld;
    logic        rsp_rdy;
    logic [31:0] rsp_dat;
    logic [1:0]  rsp_sts;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        err;
    logic        rty;

    int n_chk;
    int n_pass;
    int n_fail;

    wbn_master #(
        .AW(32), .DW(32), .SW(4), .RETRY_MAX(2), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_we(req_we),
        .req_adr(req_adr), .req_sel(req_sel), .req_dat(req_dat),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat), .rsp_sts(rsp_sts),
        .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel), .dat_w(dat_w),
        .dat_r(dat_r), .ack(ack), .err(err), .rty(rty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command, let it be accepted, then scramble the request fields.
    task automatic send(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        req_we  = w;
        req_adr = a;
        req_sel = s;
        req_dat = d;
        req_vld = 1'b1;
        chk("req_rdy_before_send", 64'(req_rdy), 64'd1);
        step();
        req_vld = 1'b0;
        req_we  = ~w;
        req_adr = 32'hFFFF_FFFF;
        req_sel = 4'h0;
        req_dat = 32'h5555_5555;
    endtask

    task automatic finish_rsp(input string tag);
        rsp_rdy = 1'b1;
        step();
        rsp_rdy = 1'b0;
        chk({tag, "_rsp_vld_drop"}, 64'(rsp_vld), 64'd0);
        chk({tag, "_req_rdy_back"}, 64'(req_rdy), 64'd1);
        chk({tag, "_cyc_idle"}, 64'(cyc), 64'd0);
    endtask

    // Up to three attempts; the first n_rty attempts are answered with rty, the next with ack.
    task automatic retry_run(input int n_rty, input logic [1:0] sts_exp, input logic [31:0] dat_exp);
        send(1'b0, 32'h0000_0030, 4'hF, 32'h0);
        for (int a = 0; a < 3; a++) begin
            chk($sformatf("rty%0d_attempt%0d_cyc", n_rty, a), 64'(cyc & stb), 64'd1);
            chk($sformatf("rty%0d_attempt%0d_adr", n_rty, a), 64'(adr), 64'h30);
            if (a < n_rty) begin
                rty = 1'b1;
                step();
                rty = 1'b0;
                if (a < 2) begin
                    chk($sformatf("rty%0d_gap%0d_cyc", n_rty, a), 64'(cyc | stb), 64'd0);
                    step();
                end
            end else begin
                ack   = 1'b1;
                dat_r = 32'hCAFE_F00D;
                step();
                ack   = 1'b0;
                dat_r = 32'h0;
                a = 3;
            end
        end
        chk($sformatf("rty%0d_rsp_vld", n_rty), 64'(rsp_vld), 64'd1);
        chk($sformatf("rty%0d_sts", n_rty), 64'(rsp_sts), 64'(sts_exp));
        chk($sformatf("rty%0d_dat", n_rty), 64'(rsp_dat), 64'(dat_exp));
        chk($sformatf("rty%0d_cyc_done", n_rty), 64'(cyc), 64'd0);
        finish_rsp($sformatf("rty%0d", n_rty));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        n_chk = 0; n_pass = 0; n_fail = 0;
        rst = 1'b1; req_vld = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
        rsp_rdy = 1'b0; dat_r = '0; ack = 1'b0; err = 1'b0; rty = 1'b0;

        step();
        step();
        chk("reset_cyc", 64'(cyc), 64'd0);
        chk("reset_stb", 64'(stb), 64'd0);
        chk("reset_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("reset_adr", 64'(adr), 64'd0);
        chk("reset_req_rdy", 64'(req_rdy), 64'd1);
        rst = 1'b0;
        step();

        // Read with ack in the third strobe cycle.
        send(1'b0, 32'h0000_0010, 4'hF, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_cyc%0d", i), 64'(cyc & stb), 64'd1);
            chk($sformatf("rd_adr%0d", i), 64'(adr), 64'h10);
            chk($sformatf("rd_sel%0d", i), 64'(sel), 64'hF);
            chk($sformatf("rd_we%0d", i), 64'(we), 64'd0);
            chk($sformatf("rd_rsp_vld%0d", i), 64'(rsp_vld), 64'd0);
            if (i == 2) begin
                ack   = 1'b1;
                dat_r = 32'hDEAD_BEEF;
            end
            step();
        end
        ack = 1'b0;
        dat_r = 32'h0;
        chk("rd_cyc_drop", 64'(cyc | stb), 64'd0);
        chk("rd_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("rd_rsp_dat", 64'(rsp_dat), 64'hDEAD_BEEF);
        chk("rd_rsp_sts", 64'(rsp_sts), 64'd0);
        finish_rsp("rd");

        // Write with ack already high (ignored in IDLE, taken in the first BUS cycle).
        ack = 1'b1;
        send(1'b1, 32'h0000_0020, 4'h3, 32'h1234_5678);
        chk("wr_cyc", 64'(cyc & stb), 64'd1);
        chk("wr_we", 64'(we), 64'd1);
        chk("wr_dat_w", 64'(dat_w), 64'h1234_5678);
        chk("wr_sel", 64'(sel), 64'h3);
        chk("wr_adr", 64'(adr), 64'h20);
        chk("wr_rsp_vld_early", 64'(rsp_vld), 64'd0);
        step();
        ack = 1'b0;
        chk("wr_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("wr_rsp_dat", 64'(rsp_dat), 64'd0);
        chk("wr_rsp_sts", 64'(rsp_sts), 64'd0);
        chk("wr_cyc_drop", 64'(cyc), 64'd0);
        finish_rsp("wr");

        retry_run(2, 2'b00, 32'hCAFE_F00D);
        retry_run(3, 2'b10, 32'h0);

        // err and ack together: err wins.
        send(1'b0, 32'h0000_0040, 4'hF, 32'h0);
        err = 1'b1;
        ack = 1'b1;
        dat_r = 32'h1111_2222;
        step();
        err = 1'b0;
        ack = 1'b0;
        dat_r = 32'h0;
        chk("err_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("err_sts", 64'(rsp_sts), 64'd1);
        chk("err_dat", 64'(rsp_dat), 64'd0);
        chk("err_cyc", 64'(cyc), 64'd0);
        finish_rsp("err");

        // Timeout: no termination at all.
        send(1'b0, 32'h0000_0050, 4'hF, 32'h0);
        n = 0;
        while (cyc === 1'b1 && n < 20) begin
            n++;
            step();
        end
        chk("tmo_stb_cycles", 64'(n), 64'd8);
        chk("tmo_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("tmo_sts", 64'(rsp_sts), 64'd3);
        chk("tmo_dat", 64'(rsp_dat), 64'd0);
        finish_rsp("tmo");

        // Response back-pressure; ack left high during RSP must be ignored.
        send(1'b0, 32'h0000_0060, 4'hF, 32'h0);
        ack = 1'b1;
        dat_r = 32'hA5A5_5A5A;
        step();
        dat_r = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("hold%0d_rsp_vld", i), 64'(rsp_vld), 64'd1);
            chk($sformatf("hold%0d_rsp_dat", i), 64'(rsp_dat), 64'hA5A5_5A5A);
            chk($sformatf("hold%0d_rsp_sts", i), 64'(rsp_sts), 64'd0);
            chk($sformatf("hold%0d_req_rdy", i), 64'(req_rdy), 64'd0);
            chk($sformatf("hold%0d_cyc", i), 64'(cyc), 64'd0);
            step();
        end
        ack = 1'b0;
        finish_rsp("hold");

        // Asynchronous reset in the middle of a bus cycle.
        send(1'b0, 32'h0000_0070, 4'hF, 32'h0);
        chk("rst_bus_cyc_before", 64'(cyc), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_async_cyc", 64'(cyc), 64'd0);
        chk("rst_async_stb", 64'(stb), 64'd0);
        chk("rst_async_rsp_vld", 64'(rsp_vld), 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("rst_after_rsp_vld", 64'(rsp_vld), 64'd0);
        chk("rst_after_req_rdy", 64'(req_rdy), 64'd1);
        chk("rst_after_cyc", 64'(cyc), 64'd0);

        ack = 1'b1;
        send(1'b1, 32'h0000_0044, 4'hF, 32'h0BAD_F00D);
        chk("post_rst_cyc", 64'(cyc), 64'd1);
        chk("post_rst_we", 64'(we), 64'd1);
        chk("post_rst_adr", 64'(adr), 64'h44);
        step();
        ack = 1'b0;
        chk("post_rst_rsp_vld", 64'(rsp_vld), 64'd1);
        chk("post_rst_sts", 64'(rsp_sts), 64'd0);
        chk("post_rst_dat", 64'(rsp_dat), 64'd0);
        finish_rsp("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
